// File: rtl/rtc_bus_cycle_pkg.sv
// Shared definitions for the RTC bus-cycle engine.
// - FSM state encoding for the two-phase multiplexed-AD access.
// - Logical register index constants (dirmem values).
// - Helpers that classify an index and map it to an RTC chip address.
package rtc_bus_cycle_pkg;

  localparam int unsigned NUM_SHADOW = 11;
  localparam int unsigned CNT_W      = 8;

  localparam logic [3:0] IDX_SEC    = 4'd1;
  localparam logic [3:0] IDX_MIN    = 4'd2;
  localparam logic [3:0] IDX_HOUR   = 4'd3;
  localparam logic [3:0] IDX_DAY    = 4'd4;
  localparam logic [3:0] IDX_MONTH  = 4'd5;
  localparam logic [3:0] IDX_YEAR   = 4'd6;
  localparam logic [3:0] IDX_TSEC   = 4'd7;
  localparam logic [3:0] IDX_TMIN   = 4'd8;
  localparam logic [3:0] IDX_THOUR  = 4'd9;
  localparam logic [3:0] IDX_LOC10  = 4'd10;
  localparam logic [3:0] IDX_LOC11  = 4'd11;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_START = 4'd1,
    S_A_SU  = 4'd2,
    S_A_STB = 4'd3,
    S_A_H   = 4'd4,
    S_A_GAP = 4'd5,
    S_D_SU  = 4'd6,
    S_D_STB = 4'd7,
    S_D_H   = 4'd8,
    S_D_GAP = 4'd9,
    S_DONE  = 4'd10
  } state_t;

  // Indices that need a real bus cycle to the RTC chip.
  function automatic logic is_bus_idx(input logic [3:0] d);
    return (d >= IDX_SEC) && (d <= IDX_THOUR);
  endfunction

  // Indices held only in the local shadow.
  function automatic logic is_local_idx(input logic [3:0] d);
    return (d == IDX_LOC10) || (d == IDX_LOC11);
  endfunction

  // Indices backed by a shadow entry (bus or local).
  function automatic logic is_shadow_idx(input logic [3:0] d);
    return (d >= IDX_SEC) && (d <= IDX_LOC11);
  endfunction

  // Shadow storage is packed from index 1, so slot = index - 1.
  function automatic logic [3:0] shadow_slot(input logic [3:0] d);
    return d - 4'd1;
  endfunction

  // Logical index -> RTC chip register address.
  function automatic logic [7:0] rtc_addr(input logic [3:0] d);
    logic [7:0] a;
    a = 8'h00;
    if ((d >= IDX_SEC) && (d <= IDX_YEAR)) begin
      a = 8'h20 + {4'h0, d};
    end else if ((d >= IDX_TSEC) && (d <= IDX_THOUR)) begin
      a = 8'h40 + {4'h0, d - 4'd6};
    end
    return a;
  endfunction

endpackage

// File: rtl/rtc_bus_cycle_if.sv
// Request/acknowledge and RTC bus signals of the bus-cycle engine.
// - slave  : the engine (takes requests, drives the RTC bus and flags).
// - master : the command side plus RTC bus model.
// Signals:
//   actesc/actlec   write/read request levels
//   dirmem/datoreg  register index / write data
//   ad_in/ad_out/ad_oe/ad_sel  multiplexed AD bus
//   cs_n/rd_n/wr_n  RTC strobes
//   esclisto/memorialisto  done levels, datomem shadow readback
interface rtc_bus_cycle_if;
  logic       actesc;
  logic       actlec;
  logic [3:0] dirmem;
  logic [7:0] datoreg;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       ad_sel;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       esclisto;
  logic       memorialisto;
  logic [7:0] datomem;

  modport slave (
    input  actesc, actlec, dirmem, datoreg, ad_in,
    output ad_out, ad_oe, ad_sel, cs_n, rd_n, wr_n,
           esclisto, memorialisto, datomem
  );

  modport master (
    output actesc, actlec, dirmem, datoreg, ad_in,
    input  ad_out, ad_oe, ad_sel, cs_n, rd_n, wr_n,
           esclisto, memorialisto, datomem
  );
endinterface

// File: rtl/rtc_bus_cycle_phase_timer.sv
// Loadable down-counter shared by every timed bus-phase state.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load_i       load load_val_i this edge (phase entry)
//   load_val_i   phase length in cycles (>=1)
//   expire_o     high while the count is 1 (last cycle of the phase)
module rtc_bus_cycle_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count parks at 1 so expire stays asserted until the next load.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q > CNT_W'(1)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/rtc_bus_cycle.sv
// RTC bus-cycle engine: turns write/read requests into an address phase
// followed by a data phase on a multiplexed AD bus, keeps an 11-entry
// shadow of the RTC registers and acknowledges with level flags.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    rtc_bus_cycle_if.slave (requests, AD bus, strobes, flags, datomem)
module rtc_bus_cycle #(
  parameter int unsigned T_SU  = 2,
  parameter int unsigned T_PW  = 4,
  parameter int unsigned T_H   = 2,
  parameter int unsigned T_GAP = 2
) (
  input  logic            clk,
  input  logic            reset,
  rtc_bus_cycle_if.slave  bus
);
  import rtc_bus_cycle_pkg::*;

  state_t     state_q;
  logic       wr_q;
  logic [3:0] dir_q;
  logic [7:0] dat_q;

  logic       cs_n_q, rd_n_q, wr_n_q, ad_oe_q, ad_sel_q;
  logic [7:0] ad_out_q;
  logic       esc_q, mem_q;
  logic [7:0] datomem_q;
  logic [7:0] shadow_q [NUM_SHADOW];

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_exp;

  // The timer is reloaded on the same edge the FSM enters the next
  // timed state, so the load value is the length of the successor phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      S_START: begin tmr_load = 1'b1;    tmr_val = CNT_W'(T_SU);  end
      S_A_SU:  begin tmr_load = tmr_exp; tmr_val = CNT_W'(T_PW);  end
      S_A_STB: begin tmr_load = tmr_exp; tmr_val = CNT_W'(T_H);   end
      S_A_H:   begin tmr_load = tmr_exp; tmr_val = CNT_W'(T_GAP); end
      S_A_GAP: begin tmr_load = tmr_exp; tmr_val = CNT_W'(T_SU);  end
      S_D_SU:  begin tmr_load = tmr_exp; tmr_val = CNT_W'(T_PW);  end
      S_D_STB: begin tmr_load = tmr_exp; tmr_val = CNT_W'(T_H);   end
      S_D_H:   begin tmr_load = tmr_exp; tmr_val = CNT_W'(T_GAP); end
      default: begin tmr_load = 1'b0;    tmr_val = '0;            end
    endcase
  end

  rtc_bus_cycle_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      dir_q     <= 4'd0;
      dat_q     <= 8'h00;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      ad_oe_q   <= 1'b0;
      ad_sel_q  <= 1'b0;
      ad_out_q  <= 8'h00;
      esc_q     <= 1'b0;
      mem_q     <= 1'b0;
      datomem_q <= 8'h00;
      for (int i = 0; i < NUM_SHADOW; i++) begin
        shadow_q[i] <= 8'h00;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // Write wins when both requests are present.
          if (bus.actesc || bus.actlec) begin
            wr_q  <= bus.actesc;
            dir_q <= bus.dirmem;
            dat_q <= bus.datoreg;
            if (is_bus_idx(bus.dirmem)) begin
              state_q <= S_START;
            end else begin
              // Local and invalid indices complete without a bus cycle.
              state_q <= S_DONE;
              if (bus.actesc) begin
                esc_q <= 1'b1;
                if (is_local_idx(bus.dirmem)) begin
                  shadow_q[shadow_slot(bus.dirmem)] <= bus.datoreg;
                end
              end else begin
                mem_q <= 1'b1;
              end
            end
          end
        end
        S_START: begin
          state_q  <= S_A_SU;
          cs_n_q   <= 1'b0;
          ad_oe_q  <= 1'b1;
          ad_sel_q <= 1'b0;
          ad_out_q <= rtc_addr(dir_q);
        end
        S_A_SU: if (tmr_exp) begin
          state_q <= S_A_STB;
          wr_n_q  <= 1'b0;
        end
        S_A_STB: if (tmr_exp) begin
          state_q <= S_A_H;
          wr_n_q  <= 1'b1;
        end
        S_A_H: if (tmr_exp) begin
          state_q <= S_A_GAP;
          cs_n_q  <= 1'b1;
          ad_oe_q <= 1'b0;
        end
        S_A_GAP: if (tmr_exp) begin
          state_q  <= S_D_SU;
          cs_n_q   <= 1'b0;
          ad_sel_q <= 1'b1;
          ad_oe_q  <= wr_q;
          ad_out_q <= wr_q ? dat_q : 8'h00;
        end
        S_D_SU: if (tmr_exp) begin
          state_q <= S_D_STB;
          if (wr_q) wr_n_q <= 1'b0;
          else      rd_n_q <= 1'b0;
        end
        S_D_STB: if (tmr_exp) begin
          // ad_in is still driven by the chip on this last strobe cycle.
          state_q <= S_D_H;
          wr_n_q  <= 1'b1;
          rd_n_q  <= 1'b1;
          shadow_q[shadow_slot(dir_q)] <= wr_q ? dat_q : bus.ad_in;
        end
        S_D_H: if (tmr_exp) begin
          state_q <= S_D_GAP;
          cs_n_q  <= 1'b1;
          ad_oe_q <= 1'b0;
        end
        S_D_GAP: if (tmr_exp) begin
          state_q  <= S_DONE;
          ad_sel_q <= 1'b0;
          ad_out_q <= 8'h00;
          if (wr_q) esc_q <= 1'b1;
          else      mem_q <= 1'b1;
        end
        S_DONE: begin
          if ((wr_q && !bus.actesc) || (!wr_q && !bus.actlec)) begin
            esc_q   <= 1'b0;
            mem_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Readback follows the live index, not the latched one.
      datomem_q <= is_shadow_idx(bus.dirmem) ? shadow_q[shadow_slot(bus.dirmem)] : 8'h00;
    end
  end

  assign bus.cs_n         = cs_n_q;
  assign bus.rd_n         = rd_n_q;
  assign bus.wr_n         = wr_n_q;
  assign bus.ad_oe        = ad_oe_q;
  assign bus.ad_sel       = ad_sel_q;
  assign bus.ad_out       = ad_out_q;
  assign bus.esclisto     = esc_q;
  assign bus.memorialisto = mem_q;
  assign bus.datomem      = datomem_q;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Scoreboard bench for rtc_bus_cycle: each scenario pushes its expected
// observations when it drives the request, captures a window of bus
// activity, then pops and compares in order.
module tb_rtc_bus_cycle;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  logic clk;
  logic reset;
  logic [7:0] rtc_val;

  rtc_bus_cycle_if bus();

  rtc_bus_cycle dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RTC chip model: drives its register value only while rd_n is low.
  assign bus.ad_in = (bus.rd_n == 1'b0) ? rtc_val : 8'hEE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  logic [31:0] obs[$];
  int          pass_cnt;
  int          total_cnt;

  logic       cap_cs  [32];
  logic       cap_wr  [32];
  logic       cap_rd  [32];
  logic       cap_oe  [32];
  logic       cap_sel [32];
  logic       cap_esc [32];
  logic       cap_mem [32];
  logic [7:0] cap_ad  [32];
  logic [7:0] cap_dm  [32];

  task automatic push_exp(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sb.push_back(e);
  endtask

  // Sample index c is taken 1 time unit after the c-th edge, c=0 being
  // the first edge that sees the newly driven request.
  task automatic capture(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      cap_cs[c]  = bus.cs_n;
      cap_wr[c]  = bus.wr_n;
      cap_rd[c]  = bus.rd_n;
      cap_oe[c]  = bus.ad_oe;
      cap_sel[c] = bus.ad_sel;
      cap_esc[c] = bus.esclisto;
      cap_mem[c] = bus.memorialisto;
      cap_ad[c]  = bus.ad_out;
      cap_dm[c]  = bus.datomem;
    end
  endtask

  function automatic logic [31:0] first_cs_low(input int n);
    for (int c = 0; c < n; c++) if (cap_cs[c] == 1'b0) return 32'(c);
    return NONE;
  endfunction

  function automatic logic [31:0] first_esc(input int n);
    for (int c = 0; c < n; c++) if (cap_esc[c] == 1'b1) return 32'(c);
    return NONE;
  endfunction

  function automatic logic [31:0] first_mem(input int n);
    for (int c = 0; c < n; c++) if (cap_mem[c] == 1'b1) return 32'(c);
    return NONE;
  endfunction

  function automatic logic [31:0] cnt_wr_low(input logic sel, input int n);
    int k = 0;
    for (int c = 0; c < n; c++) if (cap_wr[c] == 1'b0 && cap_sel[c] == sel) k++;
    return 32'(k);
  endfunction

  function automatic logic [31:0] cnt_rd_low(input int n);
    int k = 0;
    for (int c = 0; c < n; c++) if (cap_rd[c] == 1'b0) k++;
    return 32'(k);
  endfunction

  function automatic logic [31:0] ad_at_wr(input logic sel, input int n);
    for (int c = 0; c < n; c++)
      if (cap_wr[c] == 1'b0 && cap_sel[c] == sel) return {24'h0, cap_ad[c]};
    return NONE;
  endfunction

  function automatic logic [31:0] cnt_oe_data(input int n);
    int k = 0;
    for (int c = 0; c < n; c++)
      if (cap_sel[c] == 1'b1 && cap_cs[c] == 1'b0 && cap_oe[c] == 1'b1) k++;
    return 32'(k);
  endfunction

  task automatic idle_inputs();
    bus.actesc  = 1'b0;
    bus.actlec  = 1'b0;
    bus.dirmem  = 4'd0;
    bus.datoreg = 8'h00;
  endtask

  task automatic test_reset();
    int cs_low;
    @(negedge clk);
    reset       = 1'b1;
    bus.actesc  = 1'b1;
    bus.dirmem  = 4'd3;
    bus.datoreg = 8'hA5;
    push_exp("rst_cs_activity", 0);
    push_exp("rst_cs_n", 1);
    push_exp("rst_rd_n", 1);
    push_exp("rst_wr_n", 1);
    push_exp("rst_ad_oe", 0);
    push_exp("rst_ad_sel", 0);
    push_exp("rst_ad_out", 0);
    push_exp("rst_esclisto", 0);
    push_exp("rst_memorialisto", 0);
    push_exp("rst_datomem", 0);
    capture(3);
    cs_low = 0;
    for (int c = 0; c < 3; c++) if (cap_cs[c] !== 1'b1) cs_low++;
    obs.push_back(32'(cs_low));
    obs.push_back({31'h0, bus.cs_n});
    obs.push_back({31'h0, bus.rd_n});
    obs.push_back({31'h0, bus.wr_n});
    obs.push_back({31'h0, bus.ad_oe});
    obs.push_back({31'h0, bus.ad_sel});
    obs.push_back({24'h0, bus.ad_out});
    obs.push_back({31'h0, bus.esclisto});
    obs.push_back({31'h0, bus.memorialisto});
    obs.push_back({24'h0, bus.datomem});
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    while (obs.size() > 0) begin
      exp_t e;
      logic [31:0] o;
      e = sb.pop_front();
      o = obs.pop_front();
      total_cnt++;
      if (o !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
      else pass_cnt++;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write();
    @(negedge clk);
    bus.dirmem  = 4'd3;
    bus.datoreg = 8'h45;
    bus.actesc  = 1'b1;
    push_exp("wr_cs_first_low", 1);
    push_exp("wr_addr", 32'h23);
    push_exp("wr_addr_pulse", 4);
    push_exp("wr_data", 32'h45);
    push_exp("wr_data_pulse", 4);
    push_exp("wr_rd_pulse", 0);
    push_exp("wr_flag_rise", 21);
    push_exp("wr_mem_flag", NONE);
    push_exp("wr_flag_held", 1);
    push_exp("wr_flag_drop", 0);
    push_exp("wr_datomem", 32'h45);
    capture(26);
    obs.push_back(first_cs_low(26));
    obs.push_back(ad_at_wr(1'b0, 26));
    obs.push_back(cnt_wr_low(1'b0, 26));
    obs.push_back(ad_at_wr(1'b1, 26));
    obs.push_back(cnt_wr_low(1'b1, 26));
    obs.push_back(cnt_rd_low(26));
    obs.push_back(first_esc(26));
    obs.push_back(first_mem(26));
    obs.push_back({31'h0, cap_esc[25]});
    @(negedge clk);
    bus.actesc = 1'b0;
    @(posedge clk); #1;
    obs.push_back({31'h0, bus.esclisto});
    @(posedge clk); #1;
    obs.push_back({24'h0, bus.datomem});
    while (obs.size() > 0) begin
      exp_t e;
      logic [31:0] o;
      e = sb.pop_front();
      o = obs.pop_front();
      total_cnt++;
      if (o !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
      else pass_cnt++;
    end
    idle_inputs();
  endtask

  task automatic test_read(input logic [3:0] idx, input logic [7:0] val,
                           input logic [7:0] addr);
    @(negedge clk);
    rtc_val    = val;
    bus.dirmem = idx;
    bus.actlec = 1'b1;
    push_exp("rd_addr", {24'h0, addr});
    push_exp("rd_data_pulse", 4);
    push_exp("rd_wr_data_pulse", 0);
    push_exp("rd_oe_in_data", 0);
    push_exp("rd_flag_rise", 21);
    push_exp("rd_esc_flag", NONE);
    push_exp("rd_datomem", {24'h0, val});
    push_exp("rd_flag_drop", 0);
    capture(24);
    obs.push_back(ad_at_wr(1'b0, 24));
    obs.push_back(cnt_rd_low(24));
    obs.push_back(cnt_wr_low(1'b1, 24));
    obs.push_back(cnt_oe_data(24));
    obs.push_back(first_mem(24));
    obs.push_back(first_esc(24));
    obs.push_back({24'h0, cap_dm[22]});
    @(negedge clk);
    bus.actlec = 1'b0;
    rtc_val    = 8'h00;
    @(posedge clk); #1;
    obs.push_back({31'h0, bus.memorialisto});
    while (obs.size() > 0) begin
      exp_t e;
      logic [31:0] o;
      e = sb.pop_front();
      o = obs.pop_front();
      total_cnt++;
      if (o !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
      else pass_cnt++;
    end
    idle_inputs();
    @(posedge clk);
  endtask

  task automatic test_local();
    // Local entry write
    @(negedge clk);
    bus.dirmem  = 4'd10;
    bus.datoreg = 8'h5A;
    bus.actesc  = 1'b1;
    push_exp("loc_cs_activity", NONE);
    push_exp("loc_flag_rise", 0);
    push_exp("loc_datomem", 32'h5A);
    capture(4);
    obs.push_back(first_cs_low(4));
    obs.push_back(first_esc(4));
    obs.push_back({24'h0, cap_dm[1]});
    @(negedge clk);
    bus.actesc = 1'b0;
    @(posedge clk);
    // Invalid index write: acknowledged, nothing stored
    @(negedge clk);
    bus.dirmem  = 4'd12;
    bus.datoreg = 8'h77;
    bus.actesc  = 1'b1;
    push_exp("inv_cs_activity", NONE);
    push_exp("inv_flag_rise", 0);
    push_exp("inv_datomem", 0);
    capture(4);
    obs.push_back(first_cs_low(4));
    obs.push_back(first_esc(4));
    obs.push_back({24'h0, cap_dm[1]});
    @(negedge clk);
    bus.actesc = 1'b0;
    @(posedge clk);
    while (obs.size() > 0) begin
      exp_t e;
      logic [31:0] o;
      e = sb.pop_front();
      o = obs.pop_front();
      total_cnt++;
      if (o !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
      else pass_cnt++;
    end
    idle_inputs();
    @(posedge clk);
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    bus.dirmem  = 4'd1;
    bus.datoreg = 8'h99;
    bus.actesc  = 1'b1;
    bus.actlec  = 1'b1;
    push_exp("sim_addr", 32'h21);
    push_exp("sim_wr_data_pulse", 4);
    push_exp("sim_rd_pulse", 0);
    push_exp("sim_esc_rise", 21);
    push_exp("sim_mem_flag", NONE);
    push_exp("sim_datomem", 32'h99);
    capture(24);
    obs.push_back(ad_at_wr(1'b0, 24));
    obs.push_back(cnt_wr_low(1'b1, 24));
    obs.push_back(cnt_rd_low(24));
    obs.push_back(first_esc(24));
    obs.push_back(first_mem(24));
    obs.push_back({24'h0, cap_dm[23]});
    @(negedge clk);
    bus.actesc = 1'b0;
    bus.actlec = 1'b0;
    @(posedge clk);
    while (obs.size() > 0) begin
      exp_t e;
      logic [31:0] o;
      e = sb.pop_front();
      o = obs.pop_front();
      total_cnt++;
      if (o !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
      else pass_cnt++;
    end
    idle_inputs();
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic found;
    logic any_flag;
    @(negedge clk);
    bus.dirmem  = 4'd5;
    bus.datoreg = 8'h3C;
    bus.actesc  = 1'b1;
    push_exp("mid_reached_strobe", 1);
    push_exp("mid_cs_n", 1);
    push_exp("mid_wr_n", 1);
    push_exp("mid_ad_oe", 0);
    push_exp("mid_flag", 0);
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(posedge clk); #1;
      if (bus.wr_n == 1'b0 && bus.ad_sel == 1'b0) found = 1'b1;
    end
    obs.push_back({31'h0, found});
    @(negedge clk);
    reset      = 1'b1;
    bus.actesc = 1'b0;
    @(posedge clk); #1;
    obs.push_back({31'h0, bus.cs_n});
    obs.push_back({31'h0, bus.wr_n});
    obs.push_back({31'h0, bus.ad_oe});
    @(negedge clk);
    reset = 1'b0;
    any_flag = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.esclisto !== 1'b0 || bus.memorialisto !== 1'b0) any_flag = 1'b1;
    end
    obs.push_back({31'h0, any_flag});
    while (obs.size() > 0) begin
      exp_t e;
      logic [31:0] o;
      e = sb.pop_front();
      o = obs.pop_front();
      total_cnt++;
      if (o !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, o, e.val);
      else pass_cnt++;
    end
    idle_inputs();
    // A following read must run normally.
    test_read(4'd8, 8'h37, 8'h42);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rtc_val   = 8'h00;
    reset     = 1'b1;
    idle_inputs();
    test_reset();
    test_write();
    test_read(4'd7, 8'h12, 8'h41);
    test_local();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
